// File: rtl/multdiv_wb_ctrl_pkg.sv
// Shared definitions for the mult/div writeback sequencer.
// Contents:
//   state_e          - FSM state encoding (IDLE/START/WAIT/WB, 2 bits)
//   MD_STATUS_REG    - register that receives exception/timeout status codes
//   MD_MULT_EXC_CODE - status value written for a failed multiply
//   MD_DIV_EXC_CODE  - status value written for a failed divide
//   exc_code()       - picks the status code that matches the latched op
package multdiv_wb_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  localparam int MD_STATUS_REG    = 30;
  localparam int MD_MULT_EXC_CODE = 4;
  localparam int MD_DIV_EXC_CODE  = 5;

  // op_div = 1 selects the divide code, otherwise the multiply code
  function automatic int exc_code(input logic op_div, input int mult_code, input int div_code);
    return op_div ? div_code : mult_code;
  endfunction

endpackage

// File: rtl/multdiv_wb_latch.sv
// Holding register bank for the in-flight mult/div operation.
// Ports:
//   clk, rst_n       - clock and asynchronous active-low clear
//   load_op          - capture rd_in/op_div_in (issue accepted)
//   rd_in, op_div_in - destination register and op kind (1 = divide)
//   load_res         - capture res_in/exc_in (result or timeout)
//   res_in, exc_in   - result word and exception flag
//   rd_out, op_div_out, res_out, exc_out - held values
module multdiv_wb_latch #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_op,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              op_div_in,
  input  logic              load_res,
  input  logic [DATA_W-1:0] res_in,
  input  logic              exc_in,
  output logic [REG_W-1:0]  rd_out,
  output logic              op_div_out,
  output logic [DATA_W-1:0] res_out,
  output logic              exc_out
);

  logic [REG_W-1:0]  rd_q, rd_d;
  logic              op_div_q, op_div_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              exc_q, exc_d;

  // Operation fields and result fields load independently: the op is
  // captured at issue, the result many cycles later.
  always_comb begin
    rd_d     = rd_q;
    op_div_d = op_div_q;
    res_d    = res_q;
    exc_d    = exc_q;
    if (load_op) begin
      rd_d     = rd_in;
      op_div_d = op_div_in;
    end
    if (load_res) begin
      res_d = res_in;
      exc_d = exc_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      op_div_q <= 1'b0;
      res_q    <= '0;
      exc_q    <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      op_div_q <= op_div_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
    end
  end

  assign rd_out     = rd_q;
  assign op_div_out = op_div_q;
  assign res_out    = res_q;
  assign exc_out    = exc_q;

endmodule

// File: rtl/multdiv_wb_ctrl.sv
// Sequencer between X-stage decode and the multi-cycle mult/div unit.
// Accepts an issue in IDLE, pulses the unit's start line, stalls the
// pipeline until the result arrives (or a watchdog fires), then emits a
// single-cycle writeback of either the result or a status code.
// Ports:
//   clk, ctrl_reset_n          - clock, asynchronous active-low reset
//   issue_mult/issue_div       - X-stage op is mult/div (mult wins if both)
//   issue_rd                   - destination register of the issuing op
//   md_result/md_exception     - unit result and exception flag
//   md_result_rdy              - one-cycle result-valid pulse
//   ctrl_MULT/ctrl_DIV         - start pulses to the unit
//   stall                      - freezes PC and the F/D, D/X latches
//   wb_en/wb_rd/wb_data        - writeback strobe, destination, value
//   busy                       - sequencer not idle
//   err_timeout                - sticky watchdog flag (cleared by reset only)
module multdiv_wb_ctrl
  import multdiv_wb_ctrl_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int DATA_W        = 32,
  parameter int TIMEOUT       = 40,
  parameter int CNT_W         = 6,
  parameter int STATUS_REG    = MD_STATUS_REG,
  parameter int MULT_EXC_CODE = MD_MULT_EXC_CODE,
  parameter int DIV_EXC_CODE  = MD_DIV_EXC_CODE
) (
  input  logic              clk,
  input  logic              ctrl_reset_n,
  input  logic              issue_mult,
  input  logic              issue_div,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_result_rdy,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  output logic              stall,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              err_timeout
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_timeout_q, err_timeout_d;
  logic [REG_W-1:0]  wb_rd_hold_q, wb_rd_hold_d;
  logic [DATA_W-1:0] wb_data_hold_q, wb_data_hold_d;

  logic              issue_any;
  logic              timeout_hit;
  logic              load_op, load_res;
  logic              op_div_in;
  logic [DATA_W-1:0] res_in;
  logic              exc_in;

  logic [REG_W-1:0]  rd_lat;
  logic              op_div_lat;
  logic [DATA_W-1:0] res_lat;
  logic              exc_lat;

  logic [REG_W-1:0]  wb_rd_calc;
  logic [DATA_W-1:0] wb_data_calc;

  assign issue_any = issue_mult | issue_div;

  // The counter holds k in the k-th WAIT cycle (starting at 0), so the
  // last WAIT cycle is the one where it reads TIMEOUT-1 and WB follows
  // exactly TIMEOUT cycles after WAIT entry. A ready in that same cycle wins.
  assign timeout_hit = (state_q == S_WAIT) && !md_result_rdy &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  assign load_op   = (state_q == S_IDLE) && issue_any;
  assign op_div_in = !issue_mult;
  assign load_res  = (state_q == S_WAIT) && (md_result_rdy || timeout_hit);
  assign res_in    = md_result_rdy ? md_result : '0;
  assign exc_in    = md_result_rdy ? md_exception : 1'b1;

  multdiv_wb_latch #(
    .REG_W  (REG_W),
    .DATA_W (DATA_W)
  ) u_latch (
    .clk        (clk),
    .rst_n      (ctrl_reset_n),
    .load_op    (load_op),
    .rd_in      (issue_rd),
    .op_div_in  (op_div_in),
    .load_res   (load_res),
    .res_in     (res_in),
    .exc_in     (exc_in),
    .rd_out     (rd_lat),
    .op_div_out (op_div_lat),
    .res_out    (res_lat),
    .exc_out    (exc_lat)
  );

  // FSM state register plus counter, sticky flag and writeback hold regs
  always_ff @(posedge clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      err_timeout_q  <= 1'b0;
      wb_rd_hold_q   <= '0;
      wb_data_hold_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      err_timeout_q  <= err_timeout_d;
      wb_rd_hold_q   <= wb_rd_hold_d;
      wb_data_hold_q <= wb_data_hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue_any) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (md_result_rdy || timeout_hit) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, watchdog flag and writeback hold registers
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_START) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    err_timeout_d = err_timeout_q | timeout_hit;
  end

  // Exceptions and timeouts redirect the writeback to the status register
  always_comb begin
    if (exc_lat) begin
      wb_rd_calc   = REG_W'(STATUS_REG);
      wb_data_calc = DATA_W'(exc_code(op_div_lat, MULT_EXC_CODE, DIV_EXC_CODE));
    end else begin
      wb_rd_calc   = rd_lat;
      wb_data_calc = res_lat;
    end
  end

  // The hold registers keep the last WB values visible after WB, so
  // wb_rd/wb_data do not follow the latches when the next op issues.
  always_comb begin
    wb_rd_hold_d   = wb_rd_hold_q;
    wb_data_hold_d = wb_data_hold_q;
    if (state_q == S_WB) begin
      wb_rd_hold_d   = wb_rd_calc;
      wb_data_hold_d = wb_data_calc;
    end
  end

  // Output logic; stall is combinational in IDLE so the issuing
  // instruction is held in X during its own issue cycle.
  always_comb begin
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    stall     = 1'b0;
    wb_en     = 1'b0;
    wb_rd     = wb_rd_hold_q;
    wb_data   = wb_data_hold_q;
    case (state_q)
      S_IDLE: stall = issue_any;
      S_START: begin
        stall     = 1'b1;
        ctrl_MULT = !op_div_lat;
        ctrl_DIV  = op_div_lat;
      end
      S_WAIT: stall = 1'b1;
      S_WB: begin
        // r0 is never written by a normal result
        wb_en   = exc_lat || (rd_lat != '0);
        wb_rd   = wb_rd_calc;
        wb_data = wb_data_calc;
      end
      default: stall = 1'b0;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_multdiv_wb_ctrl.sv
// Directed testbench for multdiv_wb_ctrl. Inputs are driven just after
// each falling clock edge; outputs are sampled 1 ns later, well away from
// the rising edge. "Cycle n" below counts falling edges from the issue.
module tb_multdiv_wb_ctrl;

  logic        clk = 1'b0;
  logic        ctrl_reset_n;
  logic        issue_mult, issue_div;
  logic [4:0]  issue_rd;
  logic [31:0] md_result;
  logic        md_exception, md_result_rdy;
  logic        ctrl_MULT, ctrl_DIV, stall, wb_en, busy, err_timeout;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  multdiv_wb_ctrl dut (
    .clk           (clk),
    .ctrl_reset_n  (ctrl_reset_n),
    .issue_mult    (issue_mult),
    .issue_div     (issue_div),
    .issue_rd      (issue_rd),
    .md_result     (md_result),
    .md_exception  (md_exception),
    .md_result_rdy (md_result_rdy),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .stall         (stall),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  // Issue cycle then START cycle; returns positioned in the START cycle
  task automatic start_op(input logic m, input logic d, input logic [4:0] rd);
    @(negedge clk); issue_mult = m; issue_div = d; issue_rd = rd; #1;
    @(negedge clk); issue_mult = 0; issue_div = 0; issue_rd = 0; #1;
  endtask

  // n WAIT cycles without ready, one with ready; returns in the WB cycle
  task automatic finish_op(input int n, input logic [31:0] res, input logic exc);
    repeat (n) begin @(negedge clk); #1; end
    @(negedge clk); md_result_rdy = 1; md_result = res; md_exception = exc; #1;
    @(negedge clk); md_result_rdy = 0; md_exception = 0; md_result = 0; #1;
  endtask

  task automatic test_reset();
    ctrl_reset_n = 0; issue_mult = 0; issue_div = 0; issue_rd = 0;
    md_result = 0; md_exception = 0; md_result_rdy = 0;
    #2;
    check_count++;
    if ({ctrl_MULT, ctrl_DIV, stall, wb_en, busy, err_timeout} !== 6'b0) begin
      error_count++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {ctrl_MULT, ctrl_DIV, stall, wb_en, busy, err_timeout});
    end
    check_count++;
    if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      error_count++; $display("[TB] FAIL reset_wb: got rd=%0d data=%0h expected 0/0", wb_rd, wb_data);
    end
    @(negedge clk); ctrl_reset_n = 1; #1;
    check_count++;
    if (busy !== 1'b0) begin error_count++; $display("[TB] FAIL reset_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_mult_normal();
    bit stall_ok = 1;
    @(negedge clk); issue_mult = 1; issue_rd = 5'd7; #1;          // cycle 0
    check_count++;
    if (stall !== 1'b1 || ctrl_MULT !== 1'b0) begin
      error_count++; $display("[TB] FAIL mult_issue: got stall=%b ctrl_MULT=%b expected 1/0", stall, ctrl_MULT);
    end
    @(negedge clk); issue_mult = 0; issue_rd = 0; #1;              // cycle 1
    check_count++;
    if (ctrl_MULT !== 1'b1 || ctrl_DIV !== 1'b0 || stall !== 1'b1) begin
      error_count++; $display("[TB] FAIL mult_start: got MULT=%b DIV=%b stall=%b expected 1/0/1", ctrl_MULT, ctrl_DIV, stall);
    end
    for (int c = 2; c < 18; c++) begin
      @(negedge clk); #1;
      if (stall !== 1'b1 || wb_en !== 1'b0 || ctrl_MULT !== 1'b0) stall_ok = 0;
    end
    check_count++;
    if (!stall_ok) begin error_count++; $display("[TB] FAIL mult_wait_stall: got a cycle without stall expected stall=1 wb_en=0"); end
    @(negedge clk); md_result_rdy = 1; md_result = 32'h30; #1;    // cycle 18
    check_count++;
    if (stall !== 1'b1 || wb_en !== 1'b0) begin
      error_count++; $display("[TB] FAIL mult_rdy_cycle: got stall=%b wb_en=%b expected 1/0", stall, wb_en);
    end
    @(negedge clk); md_result_rdy = 0; md_result = 0; #1;         // cycle 19
    check_count++;
    if (wb_en !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h30 || stall !== 1'b0) begin
      error_count++; $display("[TB] FAIL mult_wb: got en=%b rd=%0d data=%0h stall=%b expected 1/7/30/0", wb_en, wb_rd, wb_data, stall);
    end
    @(negedge clk); #1;                                            // cycle 20
    check_count++;
    if (wb_en !== 1'b0 || busy !== 1'b0 || wb_rd !== 5'd7 || wb_data !== 32'h30) begin
      error_count++; $display("[TB] FAIL mult_hold: got en=%b busy=%b rd=%0d data=%0h expected 0/0/7/30", wb_en, busy, wb_rd, wb_data);
    end
  endtask

  task automatic test_exceptions();
    start_op(0, 1, 5'd3);
    check_count++;
    if (ctrl_DIV !== 1'b1 || ctrl_MULT !== 1'b0) begin
      error_count++; $display("[TB] FAIL div_start: got DIV=%b MULT=%b expected 1/0", ctrl_DIV, ctrl_MULT);
    end
    finish_op(2, 32'hDEAD, 1);
    check_count++;
    if (wb_en !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd5) begin
      error_count++; $display("[TB] FAIL div_exc: got en=%b rd=%0d data=%0h expected 1/30/5", wb_en, wb_rd, wb_data);
    end
    start_op(1, 0, 5'd11);
    finish_op(4, 32'hBEEF, 1);
    check_count++;
    if (wb_en !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd4) begin
      error_count++; $display("[TB] FAIL mult_exc: got en=%b rd=%0d data=%0h expected 1/30/4", wb_en, wb_rd, wb_data);
    end
  endtask

  task automatic test_boundary();
    start_op(1, 0, 5'd8);
    finish_op(39, 32'hABCD, 0);   // ready in cycle 41, the last WAIT cycle
    check_count++;
    if (wb_en !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 32'hABCD || err_timeout !== 1'b0) begin
      error_count++; $display("[TB] FAIL boundary_rdy: got en=%b rd=%0d data=%0h err=%b expected 1/8/abcd/0", wb_en, wb_rd, wb_data, err_timeout);
    end
  endtask

  task automatic test_rd_zero();
    start_op(1, 1, 5'd0);
    check_count++;
    if (ctrl_MULT !== 1'b1 || ctrl_DIV !== 1'b0) begin
      error_count++; $display("[TB] FAIL rd0_start: got MULT=%b DIV=%b expected 1/0", ctrl_MULT, ctrl_DIV);
    end
    finish_op(3, 32'h99, 0);
    check_count++;
    if (wb_en !== 1'b0 || busy !== 1'b1 || stall !== 1'b0) begin
      error_count++; $display("[TB] FAIL rd0_wb: got en=%b busy=%b stall=%b expected 0/1/0", wb_en, busy, stall);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); md_result_rdy = 1; md_result = 32'h77; #1;
    @(negedge clk); md_result_rdy = 0; md_result = 0; #1;
    check_count++;
    if (busy !== 1'b0 || wb_en !== 1'b0) begin
      error_count++; $display("[TB] FAIL spurious_rdy: got busy=%b wb_en=%b expected 0/0", busy, wb_en);
    end
    start_op(0, 1, 5'd9);
    finish_op(3, 32'h1234, 0);
    check_count++;
    if (wb_en !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'h1234) begin
      error_count++; $display("[TB] FAIL b2b_first: got en=%b rd=%0d data=%0h expected 1/9/1234", wb_en, wb_rd, wb_data);
    end
    start_op(1, 0, 5'd12);        // issued the cycle right after WB
    check_count++;
    if (ctrl_MULT !== 1'b1 || busy !== 1'b1) begin
      error_count++; $display("[TB] FAIL b2b_start: got MULT=%b busy=%b expected 1/1", ctrl_MULT, busy);
    end
    finish_op(0, 32'h5678, 0);
    check_count++;
    if (wb_en !== 1'b1 || wb_rd !== 5'd12 || wb_data !== 32'h5678) begin
      error_count++; $display("[TB] FAIL b2b_second: got en=%b rd=%0d data=%0h expected 1/12/5678", wb_en, wb_rd, wb_data);
    end
  endtask

  task automatic test_timeout();
    start_op(1, 0, 5'd5);
    repeat (40) begin @(negedge clk); #1; end   // cycle 41, last WAIT cycle
    check_count++;
    if (wb_en !== 1'b0 || busy !== 1'b1 || err_timeout !== 1'b0) begin
      error_count++; $display("[TB] FAIL timeout_pre: got en=%b busy=%b err=%b expected 0/1/0", wb_en, busy, err_timeout);
    end
    @(negedge clk); #1;                         // cycle 42 = WAIT entry + 40
    check_count++;
    if (wb_en !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd4 || err_timeout !== 1'b1 || stall !== 1'b0) begin
      error_count++; $display("[TB] FAIL timeout_wb: got en=%b rd=%0d data=%0h err=%b stall=%b expected 1/30/4/1/0", wb_en, wb_rd, wb_data, err_timeout, stall);
    end
    start_op(1, 0, 5'd6);
    finish_op(1, 32'h55, 0);
    check_count++;
    if (wb_en !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 32'h55 || err_timeout !== 1'b1) begin
      error_count++; $display("[TB] FAIL timeout_sticky: got en=%b rd=%0d data=%0h err=%b expected 1/6/55/1", wb_en, wb_rd, wb_data, err_timeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    start_op(0, 1, 5'd9);
    repeat (3) begin @(negedge clk); #1; end
    @(negedge clk); ctrl_reset_n = 0; #1;
    check_count++;
    if ({ctrl_MULT, ctrl_DIV, stall, wb_en, busy, err_timeout} !== 6'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      error_count++; $display("[TB] FAIL midwait_reset: got ctrl=%b rd=%0d data=%0h expected 000000/0/0", {ctrl_MULT, ctrl_DIV, stall, wb_en, busy, err_timeout}, wb_rd, wb_data);
    end
    @(negedge clk); ctrl_reset_n = 1; #1;
    @(negedge clk); md_result_rdy = 1; md_result = 32'h77; #1;
    @(negedge clk); md_result_rdy = 0; md_result = 0; #1;
    check_count++;
    if (wb_en !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
      error_count++; $display("[TB] FAIL midwait_rdy: got en=%b busy=%b stall=%b expected 0/0/0", wb_en, busy, stall);
    end
  endtask

  initial begin
    test_reset();
    test_mult_normal();
    test_exceptions();
    test_boundary();
    test_rd_zero();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
